// File: rtl/t04_fb_pkg.sv
// Shared constants and state encoding for the 1-bpp framebuffer writer.
// The CLR state exists only when T04_FB_CLEAR_EN is defined.
package t04_fb_pkg;

    localparam logic [31:0] FB_BASE        = 32'h3E80;
    localparam int unsigned H_PIXELS       = 640;
    localparam int unsigned V_PIXELS       = 480;
    localparam int unsigned BITS_PER_WORD  = 32;
    localparam int unsigned WORDS_PER_LINE = H_PIXELS / BITS_PER_WORD;
    localparam int unsigned FB_WORDS       = V_PIXELS * WORDS_PER_LINE;

`ifdef T04_FB_CLEAR_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_WR,
        ST_CLR
    } fb_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_WR
    } fb_state_t;
`endif

endpackage

// File: rtl/t04_fb_addr_gen.sv
// Combinational pixel-to-SRAM mapping: word address, bit index (MSB = leftmost
// pixel) and visible-area range check.
module t04_fb_addr_gen
    import t04_fb_pkg::*;
(
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [31:0] word_addr,
    output logic [4:0]  bit_idx,
    output logic        in_range
);

    logic [31:0] index;

    always_comb begin
        index     = 32'(y) * 32'(WORDS_PER_LINE) + 32'(x[9:5]);
        word_addr = FB_BASE + index;
        bit_idx   = 5'd31 - x[4:0];
        in_range  = (32'(x) < 32'(H_PIXELS)) && (32'(y) < 32'(V_PIXELS));
    end

endmodule

// File: rtl/t04_framebuffer_writer.sv
// Pixel draw requests applied to the SRAM framebuffer by read-modify-write,
// only while VGA is idle. Optional frame fill under T04_FB_CLEAR_EN.
module t04_framebuffer_writer
    import t04_fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_color,
`ifdef T04_FB_CLEAR_EN
    input  logic        clear_req,
    input  logic        clear_color,
`endif
    input  logic [1:0]  vga_state,
    input  logic        mem_ack,
    input  logic [31:0] data_from_SRAM,
    output logic [31:0] SRAM_address,
    output logic [31:0] data_to_SRAM,
    output logic        read,
    output logic        write,
    output logic [3:0]  byte_select_out,
    output logic        busy,
    output logic        pix_dropped
);

    fb_state_t   state;
    logic [31:0] gen_addr;
    logic [4:0]  gen_bit;
    logic        gen_in_range;

    logic [31:0] addr_q;
    logic [4:0]  bit_q;
    logic        color_q;
`ifdef T04_FB_CLEAR_EN
    logic [13:0] clr_cnt;
    logic        clr_color_q;
`endif

    function automatic logic [31:0] put_bit(input logic [31:0] word,
                                            input logic [4:0]  idx,
                                            input logic        val);
        logic [31:0] r;
        r      = word;
        r[idx] = val;
        return r;
    endfunction

    t04_fb_addr_gen u_addr_gen (
        .x         (pix_x),
        .y         (pix_y),
        .word_addr (gen_addr),
        .bit_idx   (gen_bit),
        .in_range  (gen_in_range)
    );

    assign pix_ready       = (state == ST_IDLE) && !rst;
    assign byte_select_out = {4{read | write}};

    // Request payload; only meaningful once the FSM has left IDLE.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            addr_q  <= gen_addr;
            bit_q   <= gen_bit;
            color_q <= pix_color;
`ifdef T04_FB_CLEAR_EN
            clr_color_q <= clear_color;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            read         <= 1'b0;
            write        <= 1'b0;
            busy         <= 1'b0;
            pix_dropped  <= 1'b0;
            SRAM_address <= 32'd0;
            data_to_SRAM <= 32'd0;
`ifdef T04_FB_CLEAR_EN
            clr_cnt      <= 14'd0;
`endif
        end else begin
            pix_dropped <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef T04_FB_CLEAR_EN
                    if (clear_req) begin
                        state   <= ST_CLR;
                        busy    <= 1'b1;
                        clr_cnt <= 14'd0;
                    end else
`endif
                    if (pix_valid) begin
                        if (gen_in_range) begin
                            state <= ST_ARB;
                            busy  <= 1'b1;
                        end else begin
                            pix_dropped <= 1'b1;
                        end
                    end
                end
                ST_ARB: begin
                    if (vga_state == 2'd0) begin
                        SRAM_address <= addr_q;
                        read         <= 1'b1;
                        state        <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (read && mem_ack) begin
                        data_to_SRAM <= put_bit(data_from_SRAM, bit_q, color_q);
                        read         <= 1'b0;
                        write        <= 1'b1;
                        state        <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (write && mem_ack) begin
                        write <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
`ifdef T04_FB_CLEAR_EN
                // VGA is re-checked before every fill word, never mid-access.
                ST_CLR: begin
                    if (!write) begin
                        if (vga_state == 2'd0) begin
                            SRAM_address <= FB_BASE + 32'(clr_cnt);
                            data_to_SRAM <= {32{clr_color_q}};
                            write        <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        write <= 1'b0;
                        if (clr_cnt == 14'(FB_WORDS - 1)) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 14'd1;
                        end
                    end
                end
`endif
                default: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t04_framebuffer_writer.sv
// Self-checking bench for t04_framebuffer_writer: vector table, corner sequences
// and a randomized run against a pixel-level framebuffer model.
module tb_t04_framebuffer_writer;
    import t04_fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_color = 1'b0;
`ifdef T04_FB_CLEAR_EN
    logic        clear_req = 1'b0;
    logic        clear_color = 1'b0;
    bit          clr_mode = 1'b0;
    int          clr_idx = 0;
    int          clr_bad = 0;
`endif
    logic [1:0]  vga_state = 2'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] data_from_SRAM = '0;
    logic [31:0] SRAM_address;
    logic [31:0] data_to_SRAM;
    logic        read;
    logic        write;
    logic [3:0]  byte_select_out;
    logic        busy;
    logic        pix_dropped;

    int checks = 0;
    int errors = 0;

    bit          pixels [0:479][0:639];
    logic [31:0] sram   [0:9599];
    int          wait_cfg = 0;
    int          wcnt = 0;
    bit          stray = 1'b0;
    int          rd_acks = 0, wr_acks = 0, drops_seen = 0, addr_err = 0, rw_cycles = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        c;
        logic [31:0] init;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        drop;
    } vec_t;
    vec_t vecs [8];

    t04_framebuffer_writer dut (
        .clk            (clk),
        .rst            (rst),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_color      (pix_color),
`ifdef T04_FB_CLEAR_EN
        .clear_req      (clear_req),
        .clear_color    (clear_color),
`endif
        .vga_state      (vga_state),
        .mem_ack        (mem_ack),
        .data_from_SRAM (data_from_SRAM),
        .SRAM_address   (SRAM_address),
        .data_to_SRAM   (data_to_SRAM),
        .read           (read),
        .write          (write),
        .byte_select_out(byte_select_out),
        .busy           (busy),
        .pix_dropped    (pix_dropped)
    );

    always #5 clk = ~clk;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= FB_BASE) && (a < FB_BASE + 32'(FB_WORDS));
    endfunction

    // SRAM model: ack after wait_cfg cycles of a held request
    always @(negedge clk) begin
        if (read === 1'b1 || write === 1'b1) begin
            if (wcnt >= wait_cfg) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (read === 1'b1)
                    data_from_SRAM = addr_ok(SRAM_address) ? sram[int'(SRAM_address - FB_BASE)] : 32'hDEADBEEF;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = stray;
            wcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (pix_dropped === 1'b1) drops_seen++;
        if (read === 1'b1 || write === 1'b1) rw_cycles++;
        if (mem_ack && read === 1'b1) begin
            rd_acks++;
            if (!addr_ok(SRAM_address)) addr_err++;
        end
        if (mem_ack && write === 1'b1) begin
            wr_acks++;
            if (addr_ok(SRAM_address)) sram[int'(SRAM_address - FB_BASE)] = data_to_SRAM;
            else addr_err++;
`ifdef T04_FB_CLEAR_EN
            if (clr_mode) begin
                if (SRAM_address !== FB_BASE + 32'(clr_idx) || data_to_SRAM !== 32'hFFFFFFFF) clr_bad++;
                clr_idx++;
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packing: leftmost pixel of a word lands in bit 31
    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] r;
        int yy, base;
        yy = w / int'(WORDS_PER_LINE);
        base = (w % int'(WORDS_PER_LINE)) * 32;
        for (int b = 0; b < 32; b++) r[31-b] = pixels[yy][base+b];
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int rw0, dr0;
        rw0 = rw_cycles;
        dr0 = drops_seen;
        if (!v.drop) sram[int'(v.addr - FB_BASE)] = v.init;
        pix_x = v.x; pix_y = v.y; pix_color = v.c; pix_valid = 1'b1;
        chk($sformatf("%s_ready_T", tag), pix_ready, 1);
        tick();
        pix_valid = 1'b0;
        if (v.drop) begin
            chk($sformatf("%s_drop_pulse", tag), pix_dropped, 1);
            chk($sformatf("%s_ready_after_drop", tag), pix_ready, 1);
            tick();
            chk($sformatf("%s_drop_single", tag), pix_dropped, 0);
            tick();
            chk($sformatf("%s_no_mem_access", tag), rw_cycles - rw0, 0);
            chk($sformatf("%s_drop_count", tag), drops_seen - dr0, 1);
        end else begin
            chk($sformatf("%s_T1_ready", tag), pix_ready, 0);
            chk($sformatf("%s_T1_read", tag), read, 0);
            chk($sformatf("%s_T1_busy", tag), busy, 1);
            tick();
            chk($sformatf("%s_T2_read", tag), read, 1);
            chk($sformatf("%s_T2_addr", tag), SRAM_address, v.addr);
            chk($sformatf("%s_T2_bsel", tag), byte_select_out, 4'hF);
            tick();
            chk($sformatf("%s_T3_write", tag), write, 1);
            chk($sformatf("%s_T3_read", tag), read, 0);
            chk($sformatf("%s_T3_addr", tag), SRAM_address, v.addr);
            chk($sformatf("%s_T3_wdata", tag), data_to_SRAM, v.wdata);
            tick();
            chk($sformatf("%s_T4_ready", tag), pix_ready, 1);
            chk($sformatf("%s_T4_write", tag), write, 0);
            chk($sformatf("%s_T4_busy", tag), busy, 0);
            chk($sformatf("%s_T4_bsel", tag), byte_select_out, 4'h0);
            chk($sformatf("%s_rw_cycles", tag), rw_cycles - rw0, 2);
            chk($sformatf("%s_sram", tag), sram[int'(v.addr - FB_BASE)], v.wdata);
        end
    endtask

    initial begin
        int rd0, wr0, dr0, exp_rw, exp_drop, to, mism;
        logic [9:0] rx, ry;
        logic rc;
        int r;

        vecs[0] = '{10'd0,    10'd0,    1'b1, 32'h00000000, 32'h00003E80, 32'h80000000, 1'b0};
        vecs[1] = '{10'd639,  10'd479,  1'b0, 32'hFFFFFFFF, 32'h000063FF, 32'hFFFFFFFE, 1'b0};
        vecs[2] = '{10'd640,  10'd0,    1'b1, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[3] = '{10'd0,    10'd480,  1'b1, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[4] = '{10'd31,   10'd0,    1'b1, 32'h00000000, 32'h00003E80, 32'h00000001, 1'b0};
        vecs[5] = '{10'd32,   10'd1,    1'b1, 32'h12345678, 32'h00003E95, 32'h92345678, 1'b0};
        vecs[6] = '{10'd100,  10'd200,  1'b0, 32'hFFFFFFFF, 32'h00004E23, 32'hF7FFFFFF, 1'b0};
        vecs[7] = '{10'd1023, 10'd1023, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1};

        for (int w = 0; w < 9600; w++) sram[w] = 32'h0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", pix_ready, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", SRAM_address, 0);
        chk("rst_wdata", data_to_SRAM, 0);
        chk("rst_dropped", pix_dropped, 0);
        chk("rst_bsel", byte_select_out, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", pix_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray acks while idle are ignored
        wr0 = wr_acks;
        stray = 1'b1;
        repeat (3) tick();
        stray = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_write", write, 0);
        chk("stray_read", read, 0);
        chk("stray_ready", pix_ready, 1);
        tick();

        // VGA stall in ARB, then VGA reclaims bus during RD
        sram[40] = 32'h0;
        pix_x = 10'd5; pix_y = 10'd2; pix_color = 1'b1; pix_valid = 1'b1;
        vga_state = 2'd1;
        tick();
        pix_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_read_%0d", i), read, 0);
            tick();
        end
        vga_state = 2'd0;
        chk("stall_read_last", read, 0);
        tick();
        chk("stall_read_go", read, 1);
        chk("stall_addr", SRAM_address, 32'h3EA8);
        vga_state = 2'd2;
        tick();
        chk("stall_write_runs", write, 1);
        chk("stall_wdata", data_to_SRAM, 32'h04000000);
        tick();
        chk("stall_idle", pix_ready, 1);
        chk("stall_sram", sram[40], 32'h04000000);
        vga_state = 2'd0;

        // Reset with the read outstanding
        wr0 = wr_acks;
        wait_cfg = 1000;
        pix_x = 10'd7; pix_y = 10'd3; pix_color = 1'b1; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        chk("mrst_read_up", read, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_ready_low", pix_ready, 0);
        tick();
        chk("mrst_read_drop", read, 0);
        chk("mrst_write", write, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", SRAM_address, 0);
        rst = 1'b0;
        wait_cfg = 0;
        tick();
        chk("mrst_ready", pix_ready, 1);
        chk("mrst_no_write", wr_acks - wr0, 0);
        run_vec(vecs[0], "mrst_fresh");

        // Randomized run against the pixel model
        for (int yy = 0; yy < 480; yy++)
            for (int xx = 0; xx < 640; xx++) pixels[yy][xx] = 1'($urandom_range(0, 1));
        for (int w = 0; w < 9600; w++) sram[w] = pack_word(w);
        rd0 = rd_acks; wr0 = wr_acks; dr0 = drops_seen; exp_rw = 0; exp_drop = 0;
        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom_range(0, 11));
            rx = (r == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
            ry = (r == 1) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
            rc = 1'($urandom_range(0, 1));
            pix_x = rx; pix_y = ry; pix_color = rc; pix_valid = 1'b1;
            to = 0;
            while (!pix_ready && to < 100) begin
                vga_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                tick();
                to++;
            end
            if (to >= 100) begin
                chk("rand_ready_timeout", 0, 1);
                break;
            end
            wait_cfg = int'($urandom_range(0, 3));
            vga_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            tick();
            pix_valid = 1'b0;
            if (rx < 10'd640 && ry < 10'd480) begin
                pixels[ry][rx] = rc;
                exp_rw++;
            end else begin
                exp_drop++;
            end
            repeat ($urandom_range(0, 2)) begin
                vga_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                tick();
            end
        end
        vga_state = 2'd0;
        to = 0;
        while (busy && to < 200) begin
            tick();
            to++;
        end
        chk("rand_drain", busy, 0);
        tick();
        mism = 0;
        for (int w = 0; w < 9600; w++) if (sram[w] !== pack_word(w)) mism++;
        chk("rand_fb_words", mism, 0);
        chk("rand_reads", rd_acks - rd0, exp_rw);
        chk("rand_writes", wr_acks - wr0, exp_rw);
        chk("rand_drops", drops_seen - dr0, exp_drop);
        chk("addr_range", addr_err, 0);

`ifdef T04_FB_CLEAR_EN
        // Whole-frame fill
        wait_cfg = 0;
        rd0 = rd_acks; wr0 = wr_acks;
        clr_mode = 1'b1;
        clear_req = 1'b1; clear_color = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr_busy", busy, 1);
        to = 0;
        while (busy && to < 30000) begin
            tick();
            to++;
        end
        clr_mode = 1'b0;
        chk("clr_done", busy, 0);
        chk("clr_writes", wr_acks - wr0, 9600);
        chk("clr_reads", rd_acks - rd0, 0);
        chk("clr_order_data", clr_bad, 0);
        chk("clr_ready", pix_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t04_framebuffer_writer.md
# t04_framebuffer_writer

Write-side companion to the VGA read path. Accepts single-pixel draw requests (x, y, colour) from game/CPU logic over a valid/ready handshake. Applies each one to the 1-bpp framebuffer in SRAM with a read-modify-write of the containing 32-bit word. Starts memory transactions only while the VGA fetch path is idle (`vga_state == 0`), so it never contends with display reads.

## Interface
- `FB_BASE`, 32'h3E80: word address of pixel (0,0).
- `H_PIXELS`, 640: visible width; must be a multiple of 32.
- `V_PIXELS`, 480: visible height.
- `WORDS_PER_LINE`, `H_PIXELS/32` (20): words per scan line.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: reset; synchronous, active-high.
- `pix_valid`  in  1: draw request present.
- `pix_ready`  out  1: writer can accept; transfer when `pix_valid && pix_ready`.
- `pix_x`  in  10: column.
- `pix_y`  in  10: row.
- `pix_color`  in  1: new bit value.
- `clear_req`  in  1: fill-frame request; present only under `T04_FB_CLEAR_EN`.
- `clear_color`  in  1: fill value; present only under `T04_FB_CLEAR_EN`.
- `vga_state`  in  2: VGA fetch state; non-zero means VGA owns SRAM.
- `mem_ack`  in  1: SRAM completes the current read/write this cycle.
- `data_from_SRAM`  in  32: read data, valid in the `mem_ack` cycle of a read.
- `SRAM_address`  out  32: word address.
- `data_to_SRAM`  out  32: write data.
- `read`  out  1: read request, held until acked.
- `write`  out  1: write request, held until acked.
- `byte_select_out`  out  4: 4'b1111 while `read` or `write`, else 4'b0000.
- `busy`  out  1: not in IDLE.
- `pix_dropped`  out  1: one-cycle pulse for an out-of-range request.

## Operation
- Address math:
  - word index = `pix_y*WORDS_PER_LINE + pix_x[9:5]`, computed in 32-bit.
  - `SRAM_address = FB_BASE + index`.
  - Pixel bit position = `31 - pix_x[4:0]` (MSB is leftmost).
- States: IDLE, ARB, RD, WR, CLR (CLR only with the macro).
- **IDLE:** `pix_ready = 1`.
  - On transfer, latch x/y/colour and go to ARB.
  - If `pix_x >= H_PIXELS` or `pix_y >= V_PIXELS`, stay in IDLE, pulse `pix_dropped` next cycle, and issue no memory access.
- **ARB:** wait until `vga_state == 0`, then drive address and assert `read`; go to RD.
- **RD:** hold `read` and address until `mem_ack`. On ack, register the word with the target bit replaced by colour into `data_to_SRAM`, deassert `read`, assert `write`; go to WR.
- **WR:** hold `write` until `mem_ack`; return to IDLE.
- `vga_state` is checked only in ARB (and between clear words). A transaction already issued runs to completion.
- No write coalescing. Every accepted in-range pixel costs exactly one read and one write.

## Timing
- Reset values: `pix_ready = 0` during reset, 1 the cycle after. All other outputs are 0, state IDLE, `SRAM_address = 0`.
- Reset mid-transaction: `read`/`write` drop the cycle after `rst` is sampled high. The partial word is discarded.
- All outputs are registered except `pix_ready` and `byte_select_out` (decoded from state).
- With `vga_state == 0` and zero-wait memory (ack in the first request cycle):
  - accept at cycle T;
  - `read` high at T+2;
  - `write` high at T+3;
  - IDLE at T+4.
  - Throughput: one pixel per 4 cycles.
- Memory wait states extend RD/WR one cycle per missing ack.
- `pix_ready` is low in every state other than IDLE.
- `mem_ack` while neither `read` nor `write` is asserted is ignored.

## Configuration
- `T04_FB_CLEAR_EN` defined:
  - In IDLE, `clear_req` has priority over `pix_valid`. It enters CLR with a 14-bit word counter at 0.
  - Each word waits for `vga_state == 0`, then issues a write-only access of `{32{clear_color}}` to `FB_BASE + counter`.
  - After the ack of word `V_PIXELS*WORDS_PER_LINE - 1` (9599), return to IDLE. `busy` stays high throughout.
- `T04_FB_CLEAR_EN` undefined: the `clear_req`/`clear_color` ports are absent, the CLR state does not exist, and `busy` covers the pixel path only.

## Structure
- Package `t04_fb_pkg`: state enum, `FB_BASE`/`H_PIXELS`/`V_PIXELS`/`WORDS_PER_LINE` defaults, bits-per-word constant.
- Sub-module `t04_fb_addr_gen` (combinational): x,y → word address and bit index, plus the range check. Shared with future blit logic.

## Test plan
- Pixel (0,0) colour 1, SRAM word 0 → read at 0x3E80; write 0x80000000 to 0x3E80; `pix_ready` back to 1 at T+4.
- Pixel (639,479) colour 0, memory returns 0xFFFFFFFF → read and write at 0x63FF; write data 0xFFFFFFFE.
- Pixel (640,0) → `pix_dropped` single pulse; `read` and `write` never asserted.
- `vga_state = 1` for 10 cycles after accept → `read` held low through the stall, asserted on the first cycle with `vga_state == 0`.
- `rst` asserted in the cycle after `read` rises, with `mem_ack` withheld → `read` 0 next cycle; no write issued; fresh request completes normally.
- With `T04_FB_CLEAR_EN`, `clear_req` with `clear_color = 1` → 9600 writes of 0xFFFFFFFF at 0x3E80..0x63FF in order, no reads, `busy` low afterwards.
